// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding N byte sources into one UART transmitter.
// Define UART_ARB_TAG_EN to precede every data byte with a tag frame {4'hA, grant_id}.
module uart_tx_arbiter #(
    parameter int N = 4,
    parameter int M = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    input  logic [N*M-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    output logic [M-1:0]         tx_byte,
    output logic                 tx_enable,
    input  logic                 tx_busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 active
);
    localparam int W = $clog2(N);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
    state_t state, state_n;
    logic [W-1:0] ptr, win, idx;
    logic [W:0] sum;
    logic found, grant, more;
    logic [M-1:0] win_data;
`ifdef UART_ARB_TAG_EN
    logic tag;
    logic [M-1:0] data_q;
    assign more = tag;
`else
    assign more = 1'b0;
`endif

    // descending scan so the requester closest to ptr is the last (winning) assignment
    always_comb begin
        win = '0;
        found = 1'b0;
        sum = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (W + 1)'(i);
            idx = W'(sum >= (W + 1)'(N) ? sum - (W + 1)'(N) : sum);
            if (req_valid[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
    end

    assign grant = !reset && state == IDLE && found && !tx_busy;
    assign win_data = M'(req_data >> (win * M));

    always_comb begin
        state_n = state;
        req_ready = grant ? N'(1) << win : '0;
        tx_enable = state == LOAD;
        active = state != IDLE;
        case (state)
            IDLE:      state_n = grant ? LOAD : IDLE;
            LOAD:      state_n = WAIT_BUSY;
            WAIT_BUSY: state_n = tx_busy ? WAIT_DONE : WAIT_BUSY;
            WAIT_DONE: state_n = tx_busy ? WAIT_DONE : (more ? LOAD : IDLE);
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_byte <= '0;
            grant_id <= '0;
            ptr <= '0;
`ifdef UART_ARB_TAG_EN
            tag <= 1'b0;
            data_q <= '0;
`endif
        end else if (grant) begin
            grant_id <= win;
            ptr <= (win == W'(N - 1)) ? '0 : win + 1'b1;
`ifdef UART_ARB_TAG_EN
            tx_byte <= M'({4'hA, 4'(win)});
            data_q <= win_data;
            tag <= 1'b1;
`else
            tx_byte <= win_data;
`endif
        end
`ifdef UART_ARB_TAG_EN
        else if (state == WAIT_DONE && !tx_busy && tag) begin
            tx_byte <= data_q;
            tag <= 1'b0;
        end
`endif
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration order, frame timing and reset behaviour.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int M = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N*M-1:0] req_data = '0;
    logic [N-1:0] req_ready;
    logic [M-1:0] tx_byte;
    logic tx_enable;
    logic tx_busy;
    logic [1:0] grant_id;
    logic active;
    logic force_busy = 1'b0;
    int busy_len = 40;
    int cnt = 0;
    int en_total = 0;
    int vectors = 0;
    int miscompares = 0;

    uart_tx_arbiter #(.N(N), .M(M)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_byte(tx_byte), .tx_enable(tx_enable),
        .tx_busy(tx_busy), .grant_id(grant_id), .active(active)
    );

    always #5 clk = ~clk;

    // transmitter model: busy for busy_len cycles starting the cycle after a load
    always @(posedge clk) begin
        if (tx_enable === 1'b1) begin
            cnt <= busy_len;
            en_total <= en_total + 1;
        end else if (cnt > 0)
            cnt <= cnt - 1;
    end
    assign tx_busy = force_busy || cnt != 0;

    task automatic do_reset();
        force_busy = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 200 && tx_busy; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_grant(output logic [N-1:0] rr, output int waits);
        rr = '0;
        waits = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (req_ready != '0) begin
                rr = req_ready;
                waits = i;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        vectors++; if (req_ready !== 4'b0) begin miscompares++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        vectors++; if (tx_enable !== 1'b0) begin miscompares++; $display("FAIL reset_tx_enable got %b want 0", tx_enable); end
        vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL reset_active got %b want 0", active); end
        vectors++; if (tx_byte !== 8'h00) begin miscompares++; $display("FAIL reset_tx_byte got %h want 00", tx_byte); end
        vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int lat, extra;
        busy_len = 40;
        @(negedge clk);
        req_data[15:8] = 8'h5A;
        req_valid = 4'b0010;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL single_ready got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        vectors++; if (tx_enable !== 1'b1) begin miscompares++; $display("FAIL single_enable got %b want 1", tx_enable); end
        vectors++; if (tx_byte !== 8'h5A) begin miscompares++; $display("FAIL single_byte got %h want 5a", tx_byte); end
        vectors++; if (grant_id !== 2'd1) begin miscompares++; $display("FAIL single_grant_id got %0d want 1", grant_id); end
        lat = 0;
        extra = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            #1;
            if (tx_enable) extra++;
            if (!active) begin lat = k; break; end
        end
        vectors++; if (lat != 42) begin miscompares++; $display("FAIL single_active_len got %0d want 42", lat); end
        vectors++; if (extra != 0) begin miscompares++; $display("FAIL single_extra_enable got %0d want 0", extra); end
    endtask

    task automatic test_round_robin();
        int exp_id[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] rr;
        int w, en0;
        busy_len = 3;
        do_reset();
        en0 = en_total;
        req_data = 32'h13121110;
        req_valid = 4'hF;
        for (int g = 0; g < 5; g++) begin
            wait_grant(rr, w);
            vectors++; if (rr !== 4'(1 << exp_id[g])) begin miscompares++; $display("FAIL rr_grant%0d got %b want %b", g, rr, 4'(1 << exp_id[g])); end
            @(negedge clk);
            #1;
            vectors++; if (tx_byte !== 8'(8'h10 + exp_id[g])) begin miscompares++; $display("FAIL rr_byte%0d got %h want %h", g, tx_byte, 8'(8'h10 + exp_id[g])); end
        end
        req_valid = '0;
        @(negedge clk);
        vectors++; if (en_total - en0 != 5) begin miscompares++; $display("FAIL rr_enable_count got %0d want 5", en_total - en0); end
    endtask

    task automatic test_wrap();
        logic [N-1:0] rr;
        int w;
        busy_len = 3;
        do_reset();
        req_valid = 4'b0100;
        wait_grant(rr, w);
        vectors++; if (rr !== 4'b0100) begin miscompares++; $display("FAIL wrap_first got %b want 0100", rr); end
        @(negedge clk);
        req_valid = 4'b0101;
        wait_grant(rr, w);
        vectors++; if (rr !== 4'b0001) begin miscompares++; $display("FAIL wrap_second got %b want 0001", rr); end
        @(negedge clk);
        wait_grant(rr, w);
        vectors++; if (rr !== 4'b0100) begin miscompares++; $display("FAIL wrap_third got %b want 0100", rr); end
        @(negedge clk);
        req_valid = 4'b0010;
        wait_grant(rr, w);
        vectors++; if (rr !== 4'b0010) begin miscompares++; $display("FAIL wrap_lone got %b want 0010", rr); end
        @(negedge clk);
        #1;
        vectors++; if (req_ready !== 4'b0) begin miscompares++; $display("FAIL wrap_busy_ready got %b want 0000", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] rr;
        int w;
        busy_len = 10;
        do_reset();
        req_valid = 4'b0001;
        wait_grant(rr, w);
        vectors++; if (rr !== 4'b0001) begin miscompares++; $display("FAIL mid_grant got %b want 0001", rr); end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        vectors++; if (active !== 1'b1) begin miscompares++; $display("FAIL mid_active_before got %b want 1", active); end
        reset = 1'b1;
        @(negedge clk);
        #1;
        vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL mid_active_after got %b want 0", active); end
        vectors++; if (tx_enable !== 1'b0) begin miscompares++; $display("FAIL mid_enable_after got %b want 0", tx_enable); end
        reset = 1'b0;
        req_valid = 4'b1000;
        wait_grant(rr, w);
        vectors++; if (rr !== 4'b1000) begin miscompares++; $display("FAIL mid_regrant got %b want 1000", rr); end
        vectors++; if (w != 7) begin miscompares++; $display("FAIL mid_regrant_wait got %0d want 7", w); end
        @(negedge clk);
        do_reset();
        req_valid = 4'b1010;
        wait_grant(rr, w);
        vectors++; if (rr !== 4'b0010) begin miscompares++; $display("FAIL mid_low_first got %b want 0010", rr); end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_busy_idle();
        busy_len = 3;
        do_reset();
        force_busy = 1'b1;
        req_valid = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (req_ready !== 4'b0) begin miscompares++; $display("FAIL busy_hold%0d got %b want 0000", i, req_ready); end
            @(negedge clk);
        end
        force_busy = 1'b0;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL busy_release got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
    endtask

`ifdef UART_ARB_TAG_EN
    task automatic test_tag();
        logic [N-1:0] rr;
        int w, gap;
        bit dropped;
        busy_len = 3;
        do_reset();
        req_data[31:24] = 8'hC3;
        req_valid = 4'b1000;
        wait_grant(rr, w);
        @(negedge clk);
        req_valid = '0;
        #1;
        vectors++; if (tx_byte !== 8'hA3 || tx_enable !== 1'b1) begin miscompares++; $display("FAIL tag_first got %h/%b want a3/1", tx_byte, tx_enable); end
        gap = 0;
        dropped = 0;
        for (int k = 1; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (!active) dropped = 1;
            if (tx_enable) begin gap = k; break; end
        end
        vectors++; if (gap == 0 || dropped || tx_byte !== 8'hC3) begin miscompares++; $display("FAIL tag_data got %h gap %0d drop %0d want c3", tx_byte, gap, dropped); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_reset_mid();
        test_busy_idle();
`ifdef UART_ARB_TAG_EN
        test_tag();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
